// File: rtl/hex_scan_ctrl.sv
// rtl/hex_scan_ctrl.sv - four-digit multiplexed hex display scanner with hw/sw source arbitration
// Optional leading-zero suppression is built when HEX_SCAN_LZ_BLANK_EN is defined.
module hex_scan_ctrl #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] sw_value,
  input  logic [15:0] hw_value,
  input  logic        hw_req,
  output logic        hw_grant,
  output logic [6:0]  seg_n,
  output logic [3:0]  an_n,
  output logic        frame_done
);

  localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_W  = CNT_W'(BLANK_CYC);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [15:0]      shadow_q, shadow_d;
  logic             hw_grant_q, hw_grant_d;
  logic             frame_done_q, frame_done_d;
  logic [3:0]       an_n_q, an_n_d;
  logic [6:0]       seg_n_q, seg_n_d;

  logic             tick;
  logic             boundary;
  logic             lz_dark;
  logic             dark;
  logic [3:0]       nibble;

  function automatic logic [6:0] hex_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign tick     = (cnt_q == CNT_LAST);
  assign boundary = tick && (idx_q == 2'd3);
  assign nibble   = shadow_q[idx_q*4 +: 4];

`ifdef HEX_SCAN_LZ_BLANK_EN
  // A digit is a leading zero when it and every more-significant nibble are zero.
  always_comb begin
    lz_dark = 1'b0;
    case (idx_q)
      2'd3:    lz_dark = (shadow_q[15:12] == 4'h0);
      2'd2:    lz_dark = (shadow_q[15:8] == 8'h00);
      2'd1:    lz_dark = (shadow_q[15:4] == 12'h000);
      default: lz_dark = 1'b0;
    endcase
  end
`else
  assign lz_dark = 1'b0;
`endif

  assign dark = (cnt_q < BLANK_W) || lz_dark;

  always_comb begin
    cnt_d        = tick ? '0 : cnt_q + 1'b1;
    idx_d        = tick ? idx_q + 2'd1 : idx_q;
    shadow_d     = shadow_q;
    hw_grant_d   = hw_grant_q;
    frame_done_d = boundary;
    // Source is sampled only at the frame edge so a frame never mixes two values.
    if (boundary) begin
      shadow_d   = hw_req ? hw_value : sw_value;
      hw_grant_d = hw_req;
    end
    an_n_d  = dark ? 4'hF : ~(4'b0001 << idx_q);
    seg_n_d = dark ? 7'h7F : hex_seg(nibble);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q        <= '0;
      idx_q        <= 2'd0;
      shadow_q     <= 16'h0000;
      hw_grant_q   <= 1'b0;
      frame_done_q <= 1'b0;
      an_n_q       <= 4'hF;
      seg_n_q      <= 7'h7F;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      hw_grant_q   <= hw_grant_d;
      frame_done_q <= frame_done_d;
      an_n_q       <= an_n_d;
      seg_n_q      <= seg_n_d;
    end
  end

  assign hw_grant   = hw_grant_q;
  assign frame_done = frame_done_q;
  assign an_n       = an_n_q;
  assign seg_n      = seg_n_q;

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// tb/tb_hex_scan_ctrl.sv - self-checking bench for hex_scan_ctrl (SCAN_DIV=8, BLANK_CYC=2)
// Also checks the leading-zero build when HEX_SCAN_LZ_BLANK_EN is defined.
module tb_hex_scan_ctrl;

  localparam int SD    = 8;
  localparam int BC    = 2;
  localparam int FRAME = 4 * SD;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] sw_value = 16'h0000;
  logic [15:0] hw_value = 16'h0000;
  logic        hw_req = 1'b0;
  logic        hw_grant;
  logic [6:0]  seg_n;
  logic [3:0]  an_n;
  logic        frame_done;

  int vectors = 0;
  int miscompares = 0;

  hex_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sw_value   (sw_value),
    .hw_value   (hw_value),
    .hw_req     (hw_req),
    .hw_grant   (hw_grant),
    .seg_n      (seg_n),
    .an_n       (an_n),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  function automatic bit lz_dark(input int d, input logic [15:0] sh);
`ifdef HEX_SCAN_LZ_BLANK_EN
    return (d > 0) && ((sh >> (4 * d)) == 16'h0000);
`else
    return 1'b0;
`endif
  endfunction

  // Model: m_pos counts edges since reset release; slot, digit and frame follow by division.
  int          m_pos = 0;
  logic [15:0] m_shadow = 16'h0000;
  logic        m_grant = 1'b0;
  logic [3:0]  e_an = 4'hF;
  logic [6:0]  e_seg = 7'h7F;
  logic        e_fd = 1'b0;
  int          m_slot, m_digit;

  always @(posedge clk) begin
    if (!reset_n) begin
      m_pos = 0; m_shadow = 16'h0000; m_grant = 1'b0;
      e_an = 4'hF; e_seg = 7'h7F; e_fd = 1'b0;
    end else begin
      m_slot  = m_pos % SD;
      m_digit = (m_pos / SD) % 4;
      e_fd    = (m_pos % FRAME) == FRAME - 1;
      if (m_slot < BC || lz_dark(m_digit, m_shadow)) begin
        e_an = 4'hF; e_seg = 7'h7F;
      end else begin
        e_an  = ~(4'b0001 << m_digit);
        e_seg = seg_tab[(m_shadow >> (4 * m_digit)) & 16'hF];
      end
      if (e_fd) begin
        m_shadow = hw_req ? hw_value : sw_value;
        m_grant  = hw_req;
      end
      m_pos++;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      chk("rst_an_n", an_n, 4'hF);
      chk("rst_seg_n", seg_n, 7'h7F);
      chk("rst_grant", hw_grant, 1'b0);
      chk("rst_frame_done", frame_done, 1'b0);
    end else begin
      chk("an_n", an_n, e_an);
      chk("seg_n", seg_n, e_seg);
      chk("hw_grant", hw_grant, m_grant);
      chk("frame_done", frame_done, e_fd);
      chk("an_onehot", ($countones(~an_n) <= 1), 1'b1);
    end
  end

  task automatic wait_pos(input int t);
    int guard = 0;
    while (m_pos != t && guard < 2000) begin
      @(posedge clk); #2;
      guard++;
    end
    if (m_pos != t) begin
      vectors++; miscompares++;
      $display("FAIL wait_pos: got %0d expected %0d", m_pos, t);
    end
  endtask

  task automatic lit(input string name, input int p, input logic [3:0] a, input logic [6:0] s);
    wait_pos(p);
    chk({name, "_an"}, an_n, a);
    chk({name, "_seg"}, seg_n, s);
  endtask

  initial begin
    sw_value = 16'h1234;
    repeat (3) @(posedge clk);
    #2;
    chk("lit_rst_an", an_n, 4'hF);
    chk("lit_rst_seg", seg_n, 7'h7F);
    reset_n = 1'b1;

    // First frame shows the cleared shadow, then 1234 from frame 1.
    lit("f0_d0", 3, 4'hE, 7'h40);
    wait_pos(32); chk("lit_fd_32", frame_done, 1'b1);
    wait_pos(33); chk("lit_fd_33", frame_done, 1'b0);
    chk("lit_blank_33", an_n, 4'hF);
    lit("f1_d0", 35, 4'hE, 7'h19);
    lit("f1_d1", 43, 4'hD, 7'h30);
    lit("f1_d2", 51, 4'hB, 7'h24);
    lit("f1_d3", 59, 4'h7, 7'h79);
    wait_pos(64); chk("lit_fd_64", frame_done, 1'b1);

    // Arbitration: request mid-frame, grant only at the boundary.
    wait_pos(70); hw_value = 16'hBEEF; hw_req = 1'b1;
    wait_pos(80); chk("lit_grant_80", hw_grant, 1'b0);
    wait_pos(96); chk("lit_grant_96", hw_grant, 1'b1);
    lit("hw_d0", 99, 4'hE, 7'h0E);
    wait_pos(100); hw_req = 1'b0;
    wait_pos(120); chk("lit_grant_120", hw_grant, 1'b1);
    wait_pos(128); chk("lit_grant_128", hw_grant, 1'b0);
    lit("sw_back_d0", 131, 4'hE, 7'h19);

    // Tearing: change sw_value during slot 2 of the frame showing 1111.
    sw_value = 16'h1111;
    wait_pos(178); sw_value = 16'h2222;
    lit("tear_d3", 187, 4'h7, 7'h79);
    lit("next_d0", 195, 4'hE, 7'h24);

    // Leading zeros.
    wait_pos(200); sw_value = 16'h0050;
    lit("lz_d0", 227, 4'hE, 7'h40);
    wait_pos(230); sw_value = 16'h0000;
    lit("lz_d1", 235, 4'hD, 7'h12);
`ifdef HEX_SCAN_LZ_BLANK_EN
    lit("lz_d2", 243, 4'hF, 7'h7F);
    lit("lz_d3", 251, 4'hF, 7'h7F);
    lit("zero_d0", 259, 4'hE, 7'h40);
    lit("zero_d1", 267, 4'hF, 7'h7F);
    lit("zero_d2", 275, 4'hF, 7'h7F);
`else
    lit("lz_d2", 243, 4'hB, 7'h40);
    lit("lz_d3", 251, 4'h7, 7'h40);
    lit("zero_d0", 259, 4'hE, 7'h40);
    lit("zero_d1", 267, 4'hD, 7'h40);
    lit("zero_d2", 275, 4'hB, 7'h40);
`endif

    // Mid-frame reset while digit 2 is lit.
    sw_value = 16'h1234;
    wait_pos(307);
    chk("lit_pre_rst_an", an_n, 4'hB);
    reset_n = 1'b0;
    #1;
    chk("lit_async_an", an_n, 4'hF);
    chk("lit_async_seg", seg_n, 7'h7F);
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b1;
    lit("post_blank", 1, 4'hF, 7'h7F);
    lit("post_d0", 3, 4'hE, 7'h40);
    chk("lit_post_grant", hw_grant, 1'b0);
    lit("post_d1", 11, 4'hD, 7'h40);
    lit("post_f1_d0", 35, 4'hE, 7'h19);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hex_scan_ctrl.md
HEX_SCAN_CTRL -- requirements
Module: hex_scan_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000: clk cycles per digit slot (legal: >= 2).
REQ-002 SHALL have parameter BLANK_CYC, default 4: cycles at the start of each slot with all anodes off (legal: 0 <= BLANK_CYC < SCAN_DIV).
REQ-003 SHALL have clk  input  1  system clock; all logic is on the rising edge.
REQ-004 SHALL have reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have sw_value  input  16  software hex value (4 nibbles; nibble 0 is rightmost) from the hex-digit PIO out_port.
REQ-006 SHALL have hw_value  input  16  hardware-requester hex value.
REQ-007 SHALL have hw_req  input  1  hardware requester asks for the display; level-sensitive.
REQ-008 SHALL have hw_grant  output  1  1 = the current frame shows hw_value; 0 = it shows sw_value.
REQ-009 SHALL have seg_n  output  7  active-low segments {g,f,e,d,c,b,a}.
REQ-010 SHALL have an_n  output  4  active-low digit enables; bit i selects nibble i.
REQ-011 SHALL have frame_done  output  1  one-cycle pulse at each frame boundary.

Function
REQ-012 SHALL keep prescaler cnt counting 0..SCAN_DIV-1 and wrapping; tick = (cnt == SCAN_DIV-1).
REQ-013 SHALL advance digit index idx (0..3) by 1 on each tick, wrapping 3->0.
REQ-014 SHALL define the frame boundary as tick with idx==3.
REQ-015 SHALL, at each frame boundary, load a 16-bit shadow register from hw_value if hw_req=1, else from sw_value, and set hw_grant=hw_req in the same edge.
REQ-016 SHALL ignore changes to sw_value, hw_value and hw_req between boundaries (no tearing); a grant change therefore takes up to 4*SCAN_DIV cycles.
REQ-017 SHALL assert frame_done for exactly one cycle: the cycle after the boundary edge.
REQ-018 SHALL register an_n and seg_n from the current cnt, idx and shadow, so both lag cnt/idx by one clk.
REQ-019 SHALL drive an_n = 4'hF when cnt < BLANK_CYC; otherwise an_n[idx]=0 and all other bits 1.
REQ-020 SHALL drive seg_n with the standard hex decode of shadow nibble idx; 0->7'h40, 1->7'h79, 8->7'h00, A->7'h08, F->7'h0E, and the usual patterns for the remaining values.
REQ-021 SHALL drive seg_n = 7'h7F whenever an_n = 4'hF.
REQ-022 SHALL have at most one an_n bit low in any cycle.

Reset
REQ-023 SHALL, while reset_n=0, force cnt=0, idx=0, shadow=16'h0000, hw_grant=0, frame_done=0, an_n=4'hF and seg_n=7'h7F.
REQ-024 SHALL, on a mid-frame reset, abandon the frame; the first frame after release starts at idx=0 showing shadow=0.

Configuration
REQ-025 SHALL use macro HEX_SCAN_LZ_BLANK_EN to control leading-zero suppression.
REQ-026 SHALL, with HEX_SCAN_LZ_BLANK_EN defined, treat digit i (i = 3, 2, 1) as blank when shadow nibbles i..3 are all zero: an_n stays 4'hF and seg_n = 7'h7F for that slot.
REQ-027 SHALL, with HEX_SCAN_LZ_BLANK_EN defined, always display digit 0.
REQ-028 SHALL, without HEX_SCAN_LZ_BLANK_EN, display all four digits unconditionally.
REQ-029 SHALL give identical slot timing, frame_done and hw_grant behaviour in both builds.

Verification (SCAN_DIV=8, BLANK_CYC=2)
REQ-030 SHALL check reset and scan: release reset with sw_value=16'h1234, hw_req=0 -> first frame shows 0000; from the second frame an_n cycles E,D,B,7 with seg_n 0x19,0x30,0x24,0x79; each slot has 2 blank cycles, and frame_done pulses every 32 cycles.
REQ-031 SHALL check arbitration: raise hw_req with hw_value=16'hBEEF mid-frame -> hw_grant and the displayed value change only at the next boundary; drop hw_req mid-frame -> hw_grant stays 1 until the following boundary.
REQ-032 SHALL check tearing: change sw_value 16'h1111 -> 16'h2222 at slot 2 -> the current frame shows 1111 throughout and the next frame shows 2222.
REQ-033 SHALL check leading-zero blanking: sw_value=16'h0050 -> with the macro, slots 3 and 2 stay dark while slots 1 and 0 show 5 and 0; without it, slots 3 and 2 show 0. sw_value=16'h0000 with the macro -> only digit 0 lights.
REQ-034 SHALL check mid-operation reset: assert reset_n for 3 cycles at idx=2 -> an_n=4'hF and seg_n=7'h7F immediately; after release, scanning restarts at idx=0 with cnt=0.
